// File: rtl/lsu_ctrl.sv
// Load/store unit: turns one EXU request into a single word-aligned memory access with byte mask.
// Optional `LSU_MISALIGN_TRAP_EN: misaligned requests return resp_err instead of being force-aligned.
module lsu_ctrl #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_valid,
  output logic        mem_wen,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] CNT_LAST = 4'(MEM_LAT - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        wen_q;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        uns_q;

  logic [1:0]  eff_off;
  logic [3:0]  req_mask;
  logic [31:0] word_addr;
  logic [31:0] ld_shift;
  logic [31:0] ld_data;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        req_misalign;
`endif

  // Lane offset is forced onto the natural boundary of the access size
  always_comb begin
    word_addr = {req_addr[31:2], 2'b00};
    eff_off   = req_addr[1:0];
    req_mask  = 4'b1111;
    case (req_size)
      2'd0: begin
        eff_off  = req_addr[1:0];
        req_mask = 4'b0001 << eff_off;
      end
      2'd1: begin
        eff_off  = req_addr[1:0] & 2'b10;
        req_mask = 4'b0011 << eff_off;
      end
      default: begin
        eff_off  = 2'b00;
        req_mask = 4'b1111;
      end
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    req_misalign = ((req_size == 2'd1) && req_addr[0]) ||
                   (req_size[1] && (req_addr[1:0] != 2'b00));
`endif
  end

  always_comb begin
    ld_shift = mem_rdata >> {off_q, 3'b000};
    ld_data  = ld_shift;
    case (size_q)
      2'd0:    ld_data = uns_q ? {24'h0, ld_shift[7:0]}  : {{24{ld_shift[7]}},  ld_shift[7:0]};
      2'd1:    ld_data = uns_q ? {16'h0, ld_shift[15:0]} : {{16{ld_shift[15]}}, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      wen_q      <= 1'b0;
      off_q      <= 2'b00;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      mem_valid  <= 1'b0;
      mem_wen    <= 1'b0;
      mem_raddr  <= 32'h0;
      mem_waddr  <= 32'h0;
      mem_wdata  <= 32'h0;
      mem_wmask  <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            wen_q     <= req_wen;
            off_q     <= eff_off;
            size_q    <= req_size;
            uns_q     <= req_unsigned;
            cnt       <= 4'd0;
            req_ready <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            if (req_misalign) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
            end else
`endif
            begin
              state     <= ACCESS;
              mem_valid <= 1'b1;
              mem_wen   <= req_wen;
              mem_raddr <= req_wen ? 32'h0 : word_addr;
              mem_waddr <= req_wen ? word_addr : 32'h0;
              mem_wdata <= req_wen ? (req_wdata << {eff_off, 3'b000}) : 32'h0;
              mem_wmask <= req_wen ? {4'b0000, req_mask} : 8'h00;
            end
          end
        end
        // Write enable only on the first cycle so a long access stores once
        ACCESS: begin
          mem_wen <= 1'b0;
          if (cnt == CNT_LAST) begin
            state      <= RESP;
            mem_valid  <= 1'b0;
            mem_raddr  <= 32'h0;
            mem_waddr  <= 32'h0;
            mem_wdata  <= 32'h0;
            mem_wmask  <= 8'h00;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= wen_q ? 32'h0 : ld_data;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized bench for lsu_ctrl: byte-array reference model plus a word-wide memory behind the mem_* port.
// Honours `LSU_MISALIGN_TRAP_EN in its expectations.
module tb_lsu_ctrl;

  localparam int unsigned LAT = 3;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_valid;
  logic        mem_wen;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_wmask;

  int errors = 0;
  int checks = 0;

  logic [31:0] envMem [64];
  logic [7:0]  refMem [256];
  logic        preloadEn;
  logic [5:0]  preloadIdx;
  logic [31:0] preloadVal;

  lsu_ctrl #(.MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = envMem[mem_raddr[7:2]];

  always @(posedge clk) begin
    if (preloadEn) begin
      envMem[preloadIdx] <= preloadVal;
    end else if (mem_valid && mem_wen) begin
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) envMem[mem_waddr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic preloadWord(input logic [5:0] idx, input logic [31:0] val);
    @(negedge clk);
    preloadEn  = 1'b1;
    preloadIdx = idx;
    preloadVal = val;
    for (int i = 0; i < 4; i++) refMem[{idx, 2'(i)}] = val[8*i +: 8];
    @(posedge clk);
    #1 preloadEn = 1'b0;
  endtask

  function automatic int unsigned sizeBytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : ((s == 2'd1) ? 2 : 4);
  endfunction

  function automatic logic [31:0] refLoad(input logic [31:0] ea, input int unsigned nb, input logic uns);
    longint unsigned v;
    v = 0;
    for (int i = 0; i < int'(nb); i++) v |= longint'(refMem[8'(ea + 32'(i))]) << (8 * i);
    if (!uns && v[8*nb-1]) v |= ~((64'd1 << (8 * nb)) - 64'd1);
    return v[31:0];
  endfunction

  // One full request/response transaction, checked against the byte-level model
  task automatic applyStimulus(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [1:0] size, input logic uns, input bit junk);
    int unsigned nb;
    logic [31:0] ea, expRdata, expWdata, cRaddr, cWaddr, cWdata, rRdata;
    logic [7:0]  expMask, cMask;
    bit          expErr, first;
    logic        rErr, rReady;
    int          n, vcnt, wcnt, respAt, expLat;

    nb     = sizeBytes(size);
    ea     = addr - (addr % nb);
    expErr = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    expErr = (addr % nb) != 0;
`endif
    expRdata = (wen || expErr) ? 32'h0 : refLoad(ea, nb, uns);
    expMask  = 8'h00;
    for (int i = 0; i < int'(nb); i++) expMask |= 8'(1) << (int'(ea[1:0]) + i);
    expWdata = wdata << (8 * int'(ea[1:0]));
    expLat   = expErr ? 1 : int'(LAT) + 1;

    @(negedge clk);
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ready_wait", 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_wen      = wen;
    req_addr     = addr;
    req_wdata    = wdata;
    req_size     = size;
    req_unsigned = uns;
    @(posedge clk);
    #1;
    if (junk) begin
      req_wen   = 1'b1;
      req_addr  = 32'h800000F0;
      req_wdata = $urandom;
      req_size  = 2'd2;
    end else begin
      req_valid = 1'b0;
    end

    vcnt = 0; wcnt = 0; respAt = 0; first = 1'b1;
    cRaddr = 32'hx; cWaddr = 32'hx; cWdata = 32'hx; cMask = 8'hx;
    rRdata = 32'hx; rErr = 1'bx; rReady = 1'bx;
    for (int c = 1; c <= int'(LAT) + 4 && respAt == 0; c++) begin
      @(negedge clk);
      if (mem_valid) begin
        vcnt++;
        if (first) begin
          cRaddr = mem_raddr; cWaddr = mem_waddr; cWdata = mem_wdata; cMask = mem_wmask;
          first = 1'b0;
        end
      end
      if (mem_wen) wcnt++;
      if (resp_valid) begin
        respAt = c; rRdata = resp_rdata; rErr = resp_err; rReady = req_ready;
      end
    end
    req_valid = 1'b0;

    checkOutput("resp_latency", 32'(respAt), 32'(expLat));
    checkOutput("resp_rdata", rRdata, expRdata);
    checkOutput("resp_err", 32'(rErr), 32'(expErr));
    checkOutput("ready_in_resp", 32'(rReady), 32'd0);
    checkOutput("mem_valid_cycles", 32'(vcnt), expErr ? 32'd0 : 32'(LAT));
    checkOutput("mem_wen_cycles", 32'(wcnt), (wen && !expErr) ? 32'd1 : 32'd0);
    if (!expErr) begin
      checkOutput("mem_raddr", cRaddr, wen ? 32'h0 : {addr[31:2], 2'b00});
      if (wen) begin
        checkOutput("mem_waddr", cWaddr, {addr[31:2], 2'b00});
        checkOutput("mem_wdata", cWdata, expWdata);
        checkOutput("mem_wmask", 32'(cMask), 32'(expMask));
      end
    end
    @(negedge clk);
    checkOutput("resp_pulse", 32'(resp_valid), 32'd0);
    checkOutput("ready_after", 32'(req_ready), 32'd1);
    checkOutput("idle_mem_valid", 32'(mem_valid), 32'd0);

    if (wen && !expErr)
      for (int i = 0; i < int'(nb); i++) refMem[8'(ea + 32'(i))] = wdata[8*i +: 8];
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    req_size = 2'd0; req_unsigned = 1'b0;
    preloadEn = 1'b0; preloadIdx = 6'd0; preloadVal = 32'h0;

    for (int i = 0; i < 64; i++) preloadWord(6'(i), $urandom);
    @(negedge clk);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'h0);
    checkOutput("rst_resp_err", 32'(resp_err), 32'd0);
    checkOutput("rst_mem_valid", 32'(mem_valid), 32'd0);
    checkOutput("rst_mem_wen", 32'(mem_wen), 32'd0);
    checkOutput("rst_mem_raddr", mem_raddr, 32'h0);
    checkOutput("rst_mem_wmask", 32'(mem_wmask), 32'd0);
    rst = 1'b0;

    preloadWord(6'd0, 32'h80112233);
    applyStimulus(1'b0, 32'h80000003, 32'h0, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h80000003, 32'h0, 2'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h80000102, 32'h0000BEEF, 2'd1, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h80000010, 32'h0, 2'd2, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h80000006, 32'h0, 2'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h80000000, 32'h000000A5, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h80000000, 32'h0, 2'd0, 1'b1, 1'b0);

    // Reset in the middle of a multi-cycle load
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h80000010; req_size = 2'd2;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checkOutput("midrst_access", 32'(mem_valid), 32'd1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_ready", 32'(req_ready), 32'd1);
    checkOutput("midrst_mem_valid", 32'(mem_valid), 32'd0);
    checkOutput("midrst_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    checkOutput("midrst_no_resp", 32'(resp_valid), 32'd0);
    checkOutput("midrst_no_access", 32'(mem_valid), 32'd0);

    for (int t = 0; t < 150; t++) begin
      applyStimulus(1'($urandom_range(0, 1)), 32'h80000000 | 32'($urandom_range(0, 255)),
                    $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
